// File: rtl/fc_layer_sched.sv
// Sequences one fully-connected layer pass: fetch each neuron's weight row, stage MAC operands,
// capture the datapath result and hand it to the sink over a valid/ready handshake.
module fc_layer_sched #(
  parameter int N_OUT = 16,
  parameter int AW    = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [255:0]   act_in,
  output logic           busy,
  output logic           done,
  output logic           w_rd_en,
  output logic [AW-1:0]  w_addr,
  input  logic [255:0]   w_data,
  input  logic [15:0]    b_data,
  output logic [255:0]   alu_a,
  output logic [255:0]   alu_w,
  output logic [15:0]    alu_b,
  input  logic [15:0]    alu_y,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [AW-1:0]  res_idx,
  output logic [15:0]    res_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_CAPT  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [AW-1:0] LAST_IDX = AW'(N_OUT - 1);

  logic [2:0]    state;
  logic [AW-1:0] idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      alu_a     <= '0;
      alu_w     <= '0;
      alu_b     <= '0;
      res_valid <= 1'b0;
      res_idx   <= '0;
      res_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            alu_a <= act_in;
            idx   <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          alu_w <= w_data;
          alu_b <= b_data;
          state <= S_CAPT;
        end
        S_CAPT: begin
          res_data  <= alu_y;
          res_idx   <= idx;
          res_valid <= 1'b1;
          state     <= S_WRITE;
        end
        S_WRITE: begin
          // Result stays presented until the sink takes it.
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + AW'(1);
              state <= S_FETCH;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign w_rd_en = (state == S_FETCH);
  assign w_addr  = idx;

endmodule

// File: tb/tb_fc_layer_sched.sv
// Randomized bench for fc_layer_sched: two instances (N_OUT=16 and N_OUT=1) against a timeline model.
module tb_fc_layer_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, res_ready;
  logic [255:0] act_in;
  logic         busy[2], done[2], w_rd_en[2], res_valid[2];
  logic [3:0]   w_addr[2], res_idx[2];
  logic [255:0] w_data[2], alu_a[2], alu_w[2];
  logic [15:0]  b_data[2], alu_b[2], alu_y[2], res_data[2];

  logic [255:0] wmem[2][16];
  logic [15:0]  bmem[2][16];

  int vec = 0;
  int mis = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  fc_layer_sched #(.N_OUT(16), .AW(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(start), .act_in(act_in),
    .busy(busy[0]), .done(done[0]), .w_rd_en(w_rd_en[0]), .w_addr(w_addr[0]),
    .w_data(w_data[0]), .b_data(b_data[0]), .alu_a(alu_a[0]), .alu_w(alu_w[0]),
    .alu_b(alu_b[0]), .alu_y(alu_y[0]), .res_valid(res_valid[0]), .res_ready(res_ready),
    .res_idx(res_idx[0]), .res_data(res_data[0])
  );

  fc_layer_sched #(.N_OUT(1), .AW(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .act_in(act_in),
    .busy(busy[1]), .done(done[1]), .w_rd_en(w_rd_en[1]), .w_addr(w_addr[1]),
    .w_data(w_data[1]), .b_data(b_data[1]), .alu_a(alu_a[1]), .alu_w(alu_w[1]),
    .alu_b(alu_b[1]), .alu_y(alu_y[1]), .res_valid(res_valid[1]), .res_ready(res_ready),
    .res_idx(res_idx[1]), .res_data(res_data[1])
  );

  // Datapath: 16 signed MACs, keep bits [23:8] of the sum, add bias.
  function automatic logic [15:0] dp(input logic [255:0] a, input logic [255:0] w, input logic [15:0] b);
    logic signed [39:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++) acc += $signed(a[16*i +: 16]) * $signed(w[16*i +: 16]);
    return acc[23:8] + b;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[16*i +: 16] = 16'($urandom);
    return v;
  endfunction

  function automatic int nout(input int d);
    return (d == 0) ? 16 : 1;
  endfunction

  always_comb begin
    alu_y[0] = dp(alu_a[0], alu_w[0], alu_b[0]);
    alu_y[1] = dp(alu_a[1], alu_w[1], alu_b[1]);
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (w_rd_en[d]) begin
        w_data[d] <= wmem[d][w_addr[d]];
        b_data[d] <= bmem[d][w_addr[d]];
      end
    end
  end

  // Model: position in the pass, counted in non-stalled cycles (1..4N neuron slots, 4N+1 = done).
  bit           m_on[2];
  int           m_pos[2];
  logic [255:0] m_act[2];
  int           mn;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      mn = nout(d);
      if (rst) begin
        m_on[d] = 1'b0; m_pos[d] = 0; m_act[d] = '0;
      end else if (!m_on[d]) begin
        if (start) begin m_on[d] = 1'b1; m_pos[d] = 1; m_act[d] = act_in; end
      end else if (m_pos[d] == 4*mn + 1) begin
        m_on[d] = 1'b0;
      end else if (!((m_pos[d] - 1) % 4 == 3 && !res_ready)) begin
        m_pos[d]++;
      end
    end
  end

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    vec++;
    if (got !== exp) begin
      mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  int cn, ck, cph;
  bit in_pass;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        cn = nout(d);
        in_pass = m_on[d] && m_pos[d] >= 1 && m_pos[d] <= 4*cn;
        ck  = (m_pos[d] - 1) / 4;
        cph = (m_pos[d] - 1) % 4;
        chk($sformatf("busy%0d", d), busy[d], m_on[d]);
        chk($sformatf("done%0d", d), done[d], m_on[d] && m_pos[d] == 4*cn + 1);
        chk($sformatf("w_rd_en%0d", d), w_rd_en[d], in_pass && cph == 0);
        chk($sformatf("res_valid%0d", d), res_valid[d], in_pass && cph == 3);
        chk($sformatf("alu_a%0d", d), alu_a[d], m_act[d]);
        if (in_pass && cph == 0) chk($sformatf("w_addr%0d", d), w_addr[d], ck);
        if (in_pass && cph == 3) begin
          chk($sformatf("res_idx%0d", d), res_idx[d], ck);
          chk($sformatf("res_data%0d", d), res_data[d], dp(m_act[d], wmem[d][ck], bmem[d][ck]));
        end
      end
    end
  end

  int done_cyc[2], done_cnt[2], hs_cnt[2];
  initial begin
    for (int d = 0; d < 2; d++) begin done_cyc[d] = 0; done_cnt[d] = 0; hs_cnt[d] = 0; end
  end
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (done[d] === 1'b1) begin done_cyc[d] = cyc; done_cnt[d]++; end
      if (res_valid[d] === 1'b1 && res_ready) hs_cnt[d]++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (!busy[0] && !busy[1]) begin ok = 1'b1; break; end
    end
    vec++;
    if (!ok) begin mis++; $display("FAIL idle_timeout: still busy after %0d cycles, expected idle", bound); end
  endtask

  int s, h0, d0, d1, stalls;
  bit found;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; res_ready = 1'b1; act_in = '0;
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 16; r++) begin wmem[d][r] = '0; bmem[d][r] = '0; end
    tick(); tick(); tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", busy[d], 1'b0);
      chk("rst_res_valid", res_valid[d], 1'b0);
      chk("rst_res_data", res_data[d], 16'h0);
      chk("rst_alu_w", alu_w[d], 256'h0);
    end
    chk_en = 1'b1;
    rst = 1'b0;
    tick();

    // Nominal pass: weights 1, activations 0x0100, zero bias -> every neuron 16.
    for (int r = 0; r < 16; r++) begin wmem[0][r] = {16{16'h0001}}; wmem[1][r] = {16{16'h0001}}; end
    act_in = {16{16'h0100}};
    start = 1'b1; s = cyc; h0 = hs_cnt[0];
    tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("nom_first_valid", res_valid[0], 1'b1);
    chk("nom_first_idx", res_idx[0], 4'd0);
    chk("nom_first_data", res_data[0], 16'd16);
    wait_idle(200);
    chk("nom_done_lat_n1", done_cyc[1] - s, 5);
    chk("nom_done_lat_n16", done_cyc[0] - s, 65);
    chk("nom_results", hs_cnt[0] - h0, 16);

    // Full-scale lane 0 on the single-neuron instance; act_in churns after start.
    wmem[1][0] = {240'h0, 16'h7FFF};
    act_in = {240'h0, 16'h7FFF};
    start = 1'b1; s = cyc;
    tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin act_in = rnd256(); tick(); end
    chk("max_valid", res_valid[1], 1'b1);
    chk("max_data", res_data[1], 16'hFF00);
    act_in = rnd256();
    wait_idle(200);
    chk("max_done_lat", done_cyc[1] - s, 5);

    // Backpressure: hold neuron 3 for 5 cycles.
    for (int r = 0; r < 16; r++) begin wmem[0][r] = rnd256(); bmem[0][r] = 16'($urandom); end
    act_in = rnd256();
    start = 1'b1; s = cyc; stalls = 0;
    tick(); start = 1'b0;
    for (int i = 0; i < 75; i++) begin
      if (res_valid[0] && res_idx[0] == 4'd3 && stalls < 5) begin res_ready = 1'b0; stalls++; end
      else res_ready = 1'b1;
      act_in = rnd256();
      tick();
    end
    res_ready = 1'b1;
    wait_idle(200);
    chk("bp_done_lat", done_cyc[0] - s, 70);

    // Start held high: passes only restart from idle.
    d0 = done_cnt[0]; d1 = done_cnt[1];
    start = 1'b1;
    repeat (135) tick();
    chk("held_passes_n16", done_cnt[0] - d0, 2);
    chk("held_passes_n1", done_cnt[1] - d1, 22);
    start = 1'b0;
    wait_idle(200);

    // Reset in WRITE of neuron 7.
    start = 1'b1;
    tick(); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (res_valid[0] && res_idx[0] == 4'd7) begin found = 1'b1; break; end
    end
    chk("abort_reach_n7", found, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy[0], 1'b0);
    chk("abort_done", done[0], 1'b0);
    chk("abort_w_rd_en", w_rd_en[0], 1'b0);
    chk("abort_res_valid", res_valid[0], 1'b0);
    chk("abort_w_addr", w_addr[0], 4'd0);
    chk("abort_res_idx", res_idx[0], 4'd0);
    chk("abort_res_data", res_data[0], 16'd0);
    chk("abort_alu_a", alu_a[0], 256'd0);
    chk("abort_alu_w", alu_w[0], 256'd0);
    chk("abort_alu_b", alu_b[0], 16'd0);
    tick();
    start = 1'b1;
    tick(); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (res_valid[0]) begin found = 1'b1; break; end
    end
    chk("restart_valid", found, 1'b1);
    chk("restart_idx", res_idx[0], 4'd0);
    wait_idle(200);

    // Randomized traffic.
    for (int it = 0; it < 8; it++) begin
      start = 1'b0; rst = 1'b0; res_ready = 1'b1;
      wait_idle(300);
      for (int d = 0; d < 2; d++)
        for (int r = 0; r < 16; r++) begin wmem[d][r] = rnd256(); bmem[d][r] = 16'($urandom); end
      for (int i = 0; i < 300; i++) begin
        act_in    = rnd256();
        start     = ($urandom_range(7) == 0);
        res_ready = ($urandom_range(3) != 0);
        rst       = ($urandom_range(399) == 0);
        tick();
      end
    end
    start = 1'b0; rst = 1'b0; res_ready = 1'b1;
    wait_idle(300);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule

// File: doc/fc_layer_sched.md
FC_LAYER_SCHED -- requirements
Module: fc_layer_sched

Interface
REQ-001 The block SHALL have parameter N_OUT, default 16, meaning the number of output neurons per layer pass (legal range 1..2^AW).
REQ-002 The block SHALL have parameter AW, default 4, meaning the weight/bias address width.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock (all logic on the rising edge).
REQ-004 The block SHALL have port rst, input, 1, meaning synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1, meaning a request to begin a layer pass.
REQ-006 The block SHALL have port act_in, input, 256, meaning 16 signed 16-bit activations, where lane k = bits [16k+15:16k] maps to MAC input k+1.
REQ-007 The block SHALL have port busy, output, 1, meaning high in any state other than IDLE.
REQ-008 The block SHALL have port done, output, 1, meaning a one-cycle pulse at the end of a pass.
REQ-009 The block SHALL have port w_rd_en, output, 1, meaning the read strobe to the weight and bias memory.
REQ-010 The block SHALL have port w_addr, output, AW, meaning the row address, equal to the neuron index.
REQ-011 The block SHALL have port w_data, input, 256, meaning the 16 weights of the row, valid exactly 1 cycle after w_rd_en.
REQ-012 The block SHALL have port b_data, input, 16, meaning the row bias, with the same timing as w_data.
REQ-013 The block SHALL have ports alu_a, output, 256; alu_w, output, 256; and alu_b, output, 16, meaning registered operands to the 16-MAC + truncate + bias datapath.
REQ-014 The block SHALL have port alu_y, input, 16, meaning the combinational signed result from the datapath.
REQ-015 The block SHALL have port res_valid, output, 1, meaning the result handshake valid.
REQ-016 The block SHALL have port res_ready, input, 1, meaning the result handshake ready (sink backpressure).
REQ-017 The block SHALL have port res_idx, output, AW, meaning the neuron index of res_data.
REQ-018 The block SHALL have port res_data, output, 16, meaning the registered neuron output.

Function
REQ-019 The block SHALL implement a state machine with states IDLE, FETCH, LOAD, CAPT, WRITE and DONE.
REQ-020 In IDLE with start=1, the block SHALL latch act_in into alu_a, clear the neuron index to 0, and go to FETCH on the next cycle.
REQ-021 In FETCH, the block SHALL assert w_rd_en=1 with w_addr=index for exactly one cycle, then go to LOAD.
REQ-022 In LOAD, the block SHALL register w_data into alu_w and b_data into alu_b, then go to CAPT.
REQ-023 In CAPT, the block SHALL register alu_y into res_data and index into res_idx, set res_valid=1, and go to WRITE.
REQ-024 In WRITE, the block SHALL hold res_valid, res_data and res_idx stable until res_valid and res_ready are both 1 on a rising edge.
REQ-025 On a WRITE handshake, the block SHALL deassert res_valid on the next cycle, then go to DONE if index = N_OUT-1, else increment index and go to FETCH.
REQ-026 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-027 Minimum per-neuron latency SHALL be 4 cycles (FETCH, LOAD, CAPT, WRITE with res_ready=1); a full pass with no stalls SHALL take 1 + 4*N_OUT cycles from start to done inclusive.
REQ-028 The block SHALL ignore start while busy=1; start asserted in the DONE cycle SHALL also be ignored.
REQ-029 alu_a SHALL remain constant for the whole pass; a change on act_in after the start cycle SHALL have no effect.
REQ-030 The index counter SHALL be AW bits wide and SHALL never exceed N_OUT-1.
REQ-031 The block SHALL perform no arithmetic on the data path; sign and width handling belong to the datapath.
REQ-032 w_rd_en SHALL be 0 in every state except FETCH.
REQ-033 With N_OUT=1, one neuron SHALL be processed, followed by DONE.

Reset
REQ-034 On rst=1 at a clock edge, the block SHALL enter IDLE with busy=0, done=0, w_rd_en=0, res_valid=0, and w_addr, res_idx, res_data, alu_a, alu_w and alu_b all 0.
REQ-035 Reset SHALL take priority over start and over a pending handshake.
REQ-036 Reset asserted mid-pass SHALL abort the pass with no done pulse, and the dropped result SHALL NOT be re-presented.

Verification
REQ-037 Nominal pass (N_OUT=16, res_ready=1, every weight=1, every activation=0x0100, bias=0) SHALL produce 16 results with res_idx 0..15 in order, done at cycle 65 after start, and res_data matching the datapath model.
REQ-038 Backpressure with res_ready=0 for 5 cycles on neuron 3 SHALL keep res_valid/res_idx=3/res_data stable, with no w_rd_en pulse until the handshake; total pass length +5 cycles.
REQ-039 Start held high through a whole pass SHALL start exactly one pass; a second pass SHALL begin only from IDLE after done.
REQ-040 Reset asserted in WRITE of neuron 7 SHALL put all outputs at reset values the next cycle with no done; a new start SHALL then restart at res_idx=0.
REQ-041 With N_OUT=1 and activation/weight lane0 = 0x7FFF, the block SHALL forward alu_y unaltered to res_data, and done SHALL assert 5 cycles after start.
REQ-042 Changing act_in each cycle after start SHALL leave alu_a equal to the value latched in the start cycle for the entire pass.
